// File: rtl/ascon_dom_pkg.sv
// Shared types, constants and helpers for the two-share masked Ascon permutation.
package ascon_dom_pkg;

  localparam int unsigned LANE_W  = 64;
  localparam int unsigned RAND_W  = 320;
  localparam int unsigned N_LANES = 5;

  typedef logic [LANE_W-1:0] lane_t;
  typedef lane_t [N_LANES-1:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DOM,
    ST_AFF,
    ST_DONE
  } fsm_e;

  // Right-rotation pairs of the linear layer, indexed by lane
  localparam int unsigned ROT_A [N_LANES] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [N_LANES] = '{28, 39, 6, 17, 41};

  function automatic logic [7:0] rc(input logic [3:0] idx);
    return {4'hf - idx, idx};
  endfunction

  function automatic lane_t ror(input lane_t x, input int unsigned n);
    return (x >> n) | (x << (LANE_W - n));
  endfunction

endpackage

// File: rtl/ascon_sbox_dom2.sv
// Two-share DOM S-box layer: affine/rand registers, registered DOM AND stage,
// combinational output affine step.
module ascon_sbox_dom2
  import ascon_dom_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              aff_en_i,
  input  logic              dom_en_i,
  input  state_t            x_a_i,
  input  state_t            x_b_i,
  input  logic [RAND_W-1:0] rand_i,
  output state_t            y_a_o,
  output state_t            y_b_o
);

  state_t            aff_a_d, aff_b_d, aff_a_q, aff_b_q;
  logic [RAND_W-1:0] rand_q;
  state_t            mask;
  state_t            inner_a_d, inner_b_d, cross_a_d, cross_b_d;
  state_t            inner_a_q, inner_b_q, cross_a_q, cross_b_q;
  state_t            chi_a, chi_b;

  function automatic state_t affine_in(input state_t x);
    state_t y;
    y    = x;
    y[0] = x[0] ^ x[4];
    y[4] = x[4] ^ x[3];
    y[2] = x[2] ^ x[1];
    return y;
  endfunction

  assign aff_a_d = affine_in(x_a_i);
  assign aff_b_d = affine_in(x_b_i);

  // Inner-domain and cross-domain products are registered separately so the
  // two shares only meet after the register boundary.
  always_comb begin
    mask      = '0;
    inner_a_d = '0;
    inner_b_d = '0;
    cross_a_d = '0;
    cross_b_d = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      mask[i]      = {rand_q[RAND_W/2 + 32*i +: 32], rand_q[32*i +: 32]};
      inner_a_d[i] = ~aff_a_q[i] & aff_a_q[(i+1) % N_LANES];
      cross_a_d[i] = (~aff_a_q[i] & aff_b_q[(i+1) % N_LANES]) ^ mask[i];
      inner_b_d[i] = aff_b_q[i] & aff_b_q[(i+1) % N_LANES];
      cross_b_d[i] = (aff_b_q[i] & aff_a_q[(i+1) % N_LANES]) ^ mask[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aff_a_q   <= '0;
      aff_b_q   <= '0;
      rand_q    <= '0;
      inner_a_q <= '0;
      inner_b_q <= '0;
      cross_a_q <= '0;
      cross_b_q <= '0;
    end else begin
      if (aff_en_i) begin
        aff_a_q <= aff_a_d;
        aff_b_q <= aff_b_d;
        rand_q  <= rand_i;
      end
      if (dom_en_i) begin
        inner_a_q <= inner_a_d;
        inner_b_q <= inner_b_d;
        cross_a_q <= cross_a_d;
        cross_b_q <= cross_b_d;
      end
    end
  end

  always_comb begin
    chi_a = '0;
    chi_b = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      chi_a[i] = aff_a_q[i] ^ inner_a_q[(i+1) % N_LANES] ^ cross_a_q[(i+1) % N_LANES];
      chi_b[i] = aff_b_q[i] ^ inner_b_q[(i+1) % N_LANES] ^ cross_b_q[(i+1) % N_LANES];
    end
    y_a_o    = chi_a;
    y_b_o    = chi_b;
    y_a_o[1] = chi_a[1] ^ chi_a[0];
    y_b_o[1] = chi_b[1] ^ chi_b[0];
    y_a_o[0] = chi_a[0] ^ chi_a[4];
    y_b_o[0] = chi_b[0] ^ chi_b[4];
    y_a_o[3] = chi_a[3] ^ chi_a[2];
    y_b_o[3] = chi_b[3] ^ chi_b[2];
    y_a_o[2] = ~chi_a[2];
  end

endmodule

// File: rtl/ascon_perm_dom2.sv
// Iterative first-order DOM Ascon permutation, 1..12 rounds, 2 cycles per round.
module ascon_perm_dom2
  import ascon_dom_pkg::*;
#(
  parameter int unsigned NR_DEFAULT = 12,
  parameter bit          ZERO_OUT   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        nr_i,
  input  logic [319:0]      state_A_i,
  input  logic [319:0]      state_B_i,
  input  logic              rand_valid_i,
  input  logic [RAND_W-1:0] rand_i,
  output logic              rand_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [319:0]      state_A_o,
  output logic [319:0]      state_B_o
);

  fsm_e       state_q, state_d;
  logic [3:0] nr_q, nr_d, cnt_q, cnt_d, nr_eff, rc_idx;
  logic       aff_en, dom_en, use_fb;
  state_t     src_a, src_b, sb_a, sb_b, lin_a, lin_b;

  assign nr_eff = (nr_i == 4'd0 || nr_i > 4'd12) ? 4'(NR_DEFAULT) : nr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      nr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      nr_q    <= nr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    nr_d         = nr_q;
    cnt_d        = cnt_q;
    aff_en       = 1'b0;
    dom_en       = 1'b0;
    use_fb       = 1'b0;
    rc_idx       = '0;
    in_ready_o   = 1'b0;
    rand_ready_o = 1'b0;
    out_valid_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready_o = rand_valid_i;
        rc_idx     = 4'd12 - nr_eff;
        if (in_valid_i && rand_valid_i) begin
          aff_en       = 1'b1;
          rand_ready_o = 1'b1;
          nr_d         = nr_eff;
          cnt_d        = '0;
          state_d      = ST_DOM;
        end
      end
      ST_DOM: begin
        dom_en  = 1'b1;
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q + 4'd1 == nr_q) ? ST_DONE : ST_AFF;
      end
      ST_AFF: begin
        use_fb = 1'b1;
        rc_idx = 4'd12 - nr_q + cnt_q;
        if (rand_valid_i) begin
          aff_en       = 1'b1;
          rand_ready_o = 1'b1;
          state_d      = ST_DOM;
        end
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Round constant goes into share A only; share B passes through untouched.
  always_comb begin
    src_a          = use_fb ? lin_a : state_A_i;
    src_b          = use_fb ? lin_b : state_B_i;
    src_a[2][7:0]  = src_a[2][7:0] ^ rc(rc_idx);
  end

  ascon_sbox_dom2 u_sbox (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .aff_en_i (aff_en),
    .dom_en_i (dom_en),
    .x_a_i    (src_a),
    .x_b_i    (src_b),
    .rand_i   (rand_i),
    .y_a_o    (sb_a),
    .y_b_o    (sb_b)
  );

  always_comb begin
    lin_a = '0;
    lin_b = '0;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      lin_a[k] = sb_a[k] ^ ror(sb_a[k], ROT_A[k]) ^ ror(sb_a[k], ROT_B[k]);
      lin_b[k] = sb_b[k] ^ ror(sb_b[k], ROT_A[k]) ^ ror(sb_b[k], ROT_B[k]);
    end
  end

  assign state_A_o = (ZERO_OUT && !out_valid_o) ? '0 : lin_a;
  assign state_B_o = (ZERO_OUT && !out_valid_o) ? '0 : lin_b;

endmodule

// File: tb/tb_ascon_perm_dom2.sv
// Directed bench for ascon_perm_dom2 against an unmasked Ascon-p reference model.
module tb_ascon_perm_dom2;

  logic         clk_i;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [3:0]   nr_i;
  logic [319:0] state_A_i, state_B_i;
  logic         rand_valid_i;
  logic [319:0] rand_i;
  logic         rand_ready_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [319:0] state_A_o, state_B_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit busy = 0;
  logic [319:0] exp_q[$];
  int job_nr, job_stall, acc_cyc, pulses;
  int exp_stall = 0;
  bit prev_ov = 0, prev_hold = 0;
  logic [319:0] prev_a, prev_b;

  ascon_perm_dom2 #(.NR_DEFAULT(12), .ZERO_OUT(1'b1)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .nr_i         (nr_i),
    .state_A_i    (state_A_i),
    .state_B_i    (state_B_i),
    .rand_valid_i (rand_valid_i),
    .rand_i       (rand_i),
    .rand_ready_o (rand_ready_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .state_A_o    (state_A_o),
    .state_B_o    (state_B_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [319:0] act,
                       input logic [319:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [319:0] rnd320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Plain unmasked Ascon-p with rounds 12-nr .. 11
  function automatic logic [319:0] ascon_p(input logic [319:0] s, input int nr);
    logic [63:0] x[5];
    logic [63:0] t[5];
    logic [319:0] r;
    for (int k = 0; k < 5; k++) x[k] = s[64*k +: 64];
    for (int rd = 12 - nr; rd < 12; rd++) begin
      x[2] = x[2] ^ 64'((15 - rd) * 16 + rd);
      x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
      for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
      for (int i = 0; i < 5; i++) x[i] ^= t[(i + 1) % 5];
      x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
      x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
      x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
      x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
      x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
      x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
    end
    for (int k = 0; k < 5; k++) r[64*k +: 64] = x[k];
    return r;
  endfunction

  function automatic int nr_model(input logic [3:0] n);
    return (n == 0 || n > 12) ? 12 : int'(n);
  endfunction

  // Compare process: every cycle, away from the active edge
  always @(negedge clk_i) begin
    bit accept;
    if (rst_i) begin
      exp_q.delete();
      busy = 0;
      prev_ov = 0;
      prev_hold = 0;
    end else begin
      check(in_ready_o === (!busy && rand_valid_i), "in_ready", 320'(in_ready_o),
            320'(!busy && rand_valid_i));
      accept = !busy && in_valid_i && rand_valid_i;
      if (accept) begin
        exp_q.push_back(ascon_p(state_A_i ^ state_B_i, nr_model(nr_i)));
        job_nr    = nr_model(nr_i);
        job_stall = exp_stall;
        acc_cyc   = cyc;
        pulses    = 0;
        busy      = 1;
      end
      if (rand_ready_o === 1'b1) pulses++;
      if (!busy)
        check(rand_ready_o === 1'b0, "rand_ready_idle", 320'(rand_ready_o), 320'd0);
      if (out_valid_o === 1'b1) begin
        if (!busy || exp_q.size() == 0) begin
          check(1'b0, "out_valid_unexpected", 320'd1, 320'd0);
        end else begin
          if (!prev_ov) begin
            check(cyc - acc_cyc == 2 * job_nr + job_stall, "latency",
                  320'(cyc - acc_cyc), 320'(2 * job_nr + job_stall));
            check(pulses == job_nr, "rand_pulses", 320'(pulses), 320'(job_nr));
          end
          check((state_A_o ^ state_B_o) === exp_q[0], "result", state_A_o ^ state_B_o,
                exp_q[0]);
          if (prev_hold) begin
            check(state_A_o === prev_a, "hold_A", state_A_o, prev_a);
            check(state_B_o === prev_b, "hold_B", state_B_o, prev_b);
          end
          if (out_ready_i) begin
            void'(exp_q.pop_front());
            busy = 0;
          end
        end
      end else begin
        check(state_A_o === '0, "zero_A", state_A_o, 320'd0);
        check(state_B_o === '0, "zero_B", state_B_o, 320'd0);
      end
      prev_ov   = (out_valid_o === 1'b1);
      prev_hold = (out_valid_o === 1'b1) && !out_ready_i;
      prev_a    = state_A_o;
      prev_b    = state_B_o;
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1 rand_i = rnd320();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic present_job(input logic [319:0] s, input logic [3:0] nr);
    logic [319:0] a;
    a          = rnd320();
    state_A_i  = a;
    state_B_i  = a ^ s;
    nr_i       = nr;
    in_valid_i = 1'b1;
  endtask

  task automatic accept_wait();
    int n = 0;
    @(negedge clk_i);
    while (in_ready_o !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    if (n >= 100) check(1'b0, "accept_timeout", 320'(n), 320'd0);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic start_job(input logic [319:0] s, input logic [3:0] nr);
    present_job(s, nr);
    accept_wait();
  endtask

  task automatic wait_done();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check(1'b0, "done_timeout", 320'(n), 320'd0);
  endtask

  initial begin
    logic [319:0] pin, iv, s2;
    rst_i = 1'b1; in_valid_i = 1'b0; nr_i = '0; state_A_i = '0; state_B_i = '0;
    rand_valid_i = 1'b1; out_ready_i = 1'b1; rand_i = '0;

    // Model pins: one round (i=11) on zero state, and the Ascon-Hash IV permutation
    pin = ascon_p(320'd0, 1);
    check(pin[63:0] === 64'h000964b00000004b, "pin_p1_x0", 320'(pin[63:0]),
          320'h000964b00000004b);
    check(pin[319:256] === 64'd0, "pin_p1_x4", 320'(pin[319:256]), 320'd0);
    iv = 320'h00400c0000000100;
    pin = ascon_p(iv, 12);
    check(pin === {64'h348fa5c9d525e140, 64'h43189921b8f8e3e8, 64'hb48a92db98d5da62,
                   64'h8bb21831c60f1002, 64'hee9398aadb67f03d}, "pin_hash_iv", pin,
          {64'h348fa5c9d525e140, 64'h43189921b8f8e3e8, 64'hb48a92db98d5da62,
           64'h8bb21831c60f1002, 64'hee9398aadb67f03d});

    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check(out_valid_o === 1'b0, "reset_out_valid", 320'(out_valid_o), 320'd0);
    check(rand_ready_o === 1'b0, "reset_rand_ready", 320'(rand_ready_o), 320'd0);
    check(state_A_o === '0, "reset_state_A", state_A_o, 320'd0);
    check(in_ready_o === 1'b1, "reset_in_ready", 320'(in_ready_o), 320'd1);
    tick();
    rand_valid_i = 1'b0;
    repeat (2) tick();
    rand_valid_i = 1'b1;

    start_job(320'd0, 4'd12);            wait_done();
    start_job(iv, 4'd12);                wait_done();
    start_job(rnd320(), 4'd6);           wait_done();
    start_job(rnd320(), 4'd8);           wait_done();
    start_job(rnd320(), 4'd1);           wait_done();
    start_job(rnd320(), 4'd0);           wait_done();
    start_job(rnd320(), 4'd15);          wait_done();

    // Rand starvation for 3 cycles in the AFF slot after round 5
    exp_stall = 3;
    start_job(rnd320(), 4'd12);
    repeat (9) tick();
    rand_valid_i = 1'b0;
    repeat (3) tick();
    rand_valid_i = 1'b1;
    wait_done();
    exp_stall = 0;

    // Backpressure with a second job already offered
    out_ready_i = 1'b0;
    start_job(rnd320(), 4'd8);
    begin
      int n = 0;
      while (out_valid_o !== 1'b1 && n < 100) begin tick(); n++; end
      if (n >= 100) check(1'b0, "bp_valid_timeout", 320'(n), 320'd0);
    end
    s2 = rnd320();
    present_job(s2, 4'd3);
    repeat (10) tick();
    out_ready_i = 1'b1;
    accept_wait();
    wait_done();

    // Reset in the middle of a job
    start_job(rnd320(), 4'd12);
    repeat (6) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check(out_valid_o === 1'b0, "rst_mid_out_valid", 320'(out_valid_o), 320'd0);
    check(state_A_o === '0 && state_B_o === '0, "rst_mid_outputs", state_A_o | state_B_o,
          320'd0);
    check(in_ready_o === 1'b1, "rst_mid_in_ready", 320'(in_ready_o), 320'd1);
    tick();
    start_job(rnd320(), 4'd5);           wait_done();

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
